// File: rtl/ram_sync_dual_port.sv
// Synchronous dual-port RAM: one load/store port and one read-only fetch port, both reads registered.
// Optional per-word even parity when RAM_PARITY_EN is defined; otherwise parity_error is tied low.
module ram_sync_dual_port #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter int DEPTH        = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      read_write,
  input  logic [DATA_SIZE/8-1:0]    byte_enable,
  input  logic [ADDRESS_SIZE-1:0]   address,
  input  logic [DATA_SIZE-1:0]      data_in,
  output logic [DATA_SIZE-1:0]      data_out,
  output logic                      data_valid,
  input  logic                      fetch_enable,
  input  logic [ADDRESS_SIZE-1:0]   fetch_address,
  output logic [DATA_SIZE-1:0]      fetch_out,
  output logic                      fetch_valid,
  output logic                      busy,
  output logic                      addr_error,
  output logic                      parity_error
);

  localparam int LANES = DATA_SIZE / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_SIZE:0] DEPTH_L  = (ADDRESS_SIZE + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  // Handshake: there is no backpressure. A request is accepted on any rising edge where
  // busy is low; data_valid / fetch_valid / addr_error are single-cycle pulses one edge later.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic                 ready;
  logic                 a_in_range, f_in_range;
  logic [IDX_W-1:0]     a_idx, f_idx;
  logic [DATA_SIZE-1:0] rd_word, f_word, wr_word, fetch_word;
  logic                 wr_en, rd_fire, f_fire, collide;

  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic [DATA_SIZE-1:0] fetch_out_q, fetch_out_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic                 addr_error_q, addr_error_d;

  // Clear sequencer: one word per cycle, then parks in READY until the next reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_IDX) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  assign ready = (state_q == ST_READY);
  assign busy  = (state_q == ST_CLEAR);

  // Range checks use the full address so that holes above DEPTH never alias onto real words.
  assign a_in_range = ({1'b0, address} < DEPTH_L);
  assign f_in_range = ({1'b0, fetch_address} < DEPTH_L);
  assign a_idx      = address[IDX_W-1:0];
  assign f_idx      = fetch_address[IDX_W-1:0];

  assign rd_word = mem[a_idx];
  assign f_word  = mem[f_idx];

  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < LANES; i++) begin
      if (byte_enable[i]) begin
        wr_word[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  assign wr_en   = ready & enable & ~read_write & a_in_range & (|byte_enable);
  assign rd_fire = ready & enable & read_write;
  assign f_fire  = ready & fetch_enable;

  // Write-first forwarding: a fetch hitting the word being written sees the merged word.
  assign collide    = wr_en & (address == fetch_address);
  assign fetch_word = collide ? wr_word : f_word;

  always_comb begin
    data_out_d    = data_out_q;
    data_valid_d  = rd_fire;
    fetch_out_d   = fetch_out_q;
    fetch_valid_d = f_fire;
    addr_error_d  = (ready & enable & ~a_in_range) | (f_fire & ~f_in_range);
    if (rd_fire) begin
      data_out_d = a_in_range ? rd_word : '0;
    end
    if (f_fire) begin
      fetch_out_d = f_in_range ? fetch_word : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      fetch_out_q   <= '0;
      fetch_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      fetch_out_q   <= fetch_out_d;
      fetch_valid_q <= fetch_valid_d;
      addr_error_q  <= addr_error_d;
    end
  end

  // Storage array carries no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      mem[a_idx] <= wr_word;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign fetch_out   = fetch_out_q;
  assign fetch_valid = fetch_valid_q;
  assign addr_error  = addr_error_q;

`ifdef RAM_PARITY_EN
  logic mem_par [DEPTH];
  logic rd_par_bad, f_par_bad;
  logic parity_error_q, parity_error_d;

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_par[clr_ptr_q] <= 1'b0;
    end else if (wr_en) begin
      mem_par[a_idx] <= ^wr_word;
    end
  end

  // A forwarded fetch carries freshly computed parity, so it cannot mismatch.
  always_comb begin
    rd_par_bad     = rd_fire & a_in_range & ((^rd_word) != mem_par[a_idx]);
    f_par_bad      = f_fire & f_in_range & ~collide & ((^f_word) != mem_par[f_idx]);
    parity_error_d = rd_par_bad | f_par_bad;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_error_q <= 1'b0;
    end else begin
      parity_error_q <= parity_error_d;
    end
  end

  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_dual_port.sv
// Bench for ram_sync_dual_port: reset/clear timing, a directed vector table, and randomized
// traffic against an array-based memory model. Parity corruption check runs with RAM_PARITY_EN.
module tb_ram_sync_dual_port;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int BW    = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable, read_write, fetch_enable;
  logic [BW-1:0] byte_enable;
  logic [AW-1:0] address, fetch_address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out, fetch_out;
  logic          data_valid, fetch_valid, busy, addr_error, parity_error;

  ram_sync_dual_port #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .read_write(read_write),
    .byte_enable(byte_enable), .address(address), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .fetch_enable(fetch_enable),
    .fetch_address(fetch_address), .fetch_out(fetch_out), .fetch_valid(fetch_valid),
    .busy(busy), .addr_error(addr_error), .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain word array plus the held output values.
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] m_dout, m_fout;
  logic          m_dv, m_fv, m_err;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          en;
    logic          rw;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          fen;
    logic [AW-1:0] faddr;
    logic [DW-1:0] dout;
    logic          dv;
    logic [DW-1:0] fout;
    logic          fv;
    logic          err;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    m_dout = '0;
    m_fout = '0;
    m_dv   = 1'b0;
    m_fv   = 1'b0;
    m_err  = 1'b0;
  endtask

  // Spec rules: writes land first (write-first to fetch), out-of-range reads give 0, no wrap.
  task automatic model_step(input logic en, input logic rw, input logic [BW-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic fe, input logic [AW-1:0] fa);
    bit a_oor, f_oor;
    a_oor = (int'(a) >= DEPTH);
    f_oor = (int'(fa) >= DEPTH);
    if (en && !rw && !a_oor) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) exp_mem[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    m_dv = en && rw;
    if (m_dv) m_dout = a_oor ? '0 : exp_mem[a];
    m_fv = fe;
    if (m_fv) m_fout = f_oor ? '0 : exp_mem[fa];
    m_err = (en && a_oor) || (fe && f_oor);
  endtask

  task automatic idle_inputs();
    enable        = 1'b0;
    read_write    = 1'b0;
    byte_enable   = '0;
    address       = '0;
    data_in       = '0;
    fetch_enable  = 1'b0;
    fetch_address = '0;
  endtask

  // Called just after a rising edge; drives one request cycle and samples 1 ns after the next edge.
  task automatic apply(input logic en, input logic rw, input logic [BW-1:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic fe, input logic [AW-1:0] fa);
    enable        = en;
    read_write    = rw;
    byte_enable   = be;
    address       = a;
    data_in       = d;
    fetch_enable  = fe;
    fetch_address = fa;
    model_step(en, rw, be, a, d, fe, fa);
    @(posedge clk);
    #1;
  endtask

  // Counts edges while busy; requests held active throughout must all be dropped.
  task automatic wait_clear(input string name);
    int cnt;
    logic dropped_bad;
    cnt         = 0;
    dropped_bad = 1'b0;
    enable        = 1'b1;
    read_write    = 1'b1;
    address       = 16'd2000;
    fetch_enable  = 1'b1;
    fetch_address = 16'd5;
    while (busy === 1'b1 && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (data_valid !== 1'b0 || fetch_valid !== 1'b0 || addr_error !== 1'b0) dropped_bad = 1'b1;
    end
    idle_inputs();
    check({name, " busy_cycles"}, 32'(cnt), 32'd1024);
    check1({name, " busy_dropped_req"}, dropped_bad, 1'b0);
    check1({name, " busy_low_after"}, busy, 1'b0);
    model_reset();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " data_out"}, data_out, '0);
    check1({name, " data_valid"}, data_valid, 1'b0);
    check({name, " fetch_out"}, fetch_out, '0);
    check1({name, " fetch_valid"}, fetch_valid, 1'b0);
    check1({name, " addr_error"}, addr_error, 1'b0);
    check1({name, " parity_error"}, parity_error, 1'b0);
    check1({name, " busy"}, busy, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] r_be;
    logic [AW-1:0] r_a, r_fa;
    logic [DW-1:0] r_d, q_exp;
    logic          r_en, r_rw, r_fe;

    tbl[0]  = '{1'b1, 1'b0, 4'hF, 16'd0,    32'h671A561D, 1'b0, 16'd0,    32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 16'd1,    32'hFFFFFFFF, 1'b0, 16'd0,    32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 16'd0,    32'h00000000, 1'b0, 16'd0,    32'h671A561D, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'h0, 16'd1,    32'h00000000, 1'b0, 16'd0,    32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 16'd0,    32'h00000000, 1'b0, 16'd0,    32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'hF, 16'd5,    32'hAABBCCDD, 1'b0, 16'd0,    32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'h5, 16'd5,    32'h11223344, 1'b0, 16'd0,    32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 16'd5,    32'h00000000, 1'b0, 16'd0,    32'hAA22CC44, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'hC, 16'd7,    32'hDEADBEEF, 1'b1, 16'd7,    32'hAA22CC44, 1'b0, 32'hDEAD0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 16'd2000, 32'h00000000, 1'b0, 16'd0,    32'h00000000, 1'b1, 32'hDEAD0000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 4'hF, 16'd2000, 32'h12345678, 1'b0, 16'd0,    32'h00000000, 1'b0, 32'hDEAD0000, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'h0, 16'd7,    32'h00000000, 1'b1, 16'd1023, 32'hDEAD0000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'h0, 16'd3000, 32'h00000000, 1'b1, 16'd2000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 16'd1,    32'h00000000, 1'b0, 16'd0,    32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 16'd1,    32'h00000000, 1'b1, 16'd0,    32'hFFFFFFFF, 1'b1, 32'h671A561D, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 4'hF, 16'd1027, 32'hAAAA5555, 1'b0, 16'd0,    32'hFFFFFFFF, 1'b0, 32'h671A561D, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 4'h0, 16'd3,    32'h00000000, 1'b1, 16'd1024, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 4'hF, 16'd1023, 32'hCAFEF00D, 1'b1, 16'd1023, 32'h00000000, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 4'h0, 16'd1023, 32'h00000000, 1'b0, 16'd0,    32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 16'd0,    32'h00000000, 1'b0, 16'd0,    32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};

    // Reset and first clear sequence
    reset_n = 1'b0;
    idle_inputs();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    check1("busy_after_release", busy, 1'b1);
    wait_clear("clear1");

    apply(1'b1, 1'b1, 4'h0, 16'd1023, '0, 1'b0, 16'd0);
    check("clear1 read1023", data_out, 32'h0);
    check1("clear1 read1023 valid", data_valid, 1'b1);

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].en, tbl[i].rw, tbl[i].be, tbl[i].addr, tbl[i].din,
            tbl[i].fen, tbl[i].faddr);
      check($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
      check1($sformatf("vec%0d data_valid", i), data_valid, tbl[i].dv);
      check($sformatf("vec%0d fetch_out", i), fetch_out, tbl[i].fout);
      check1($sformatf("vec%0d fetch_valid", i), fetch_valid, tbl[i].fv);
      check1($sformatf("vec%0d addr_error", i), addr_error, tbl[i].err);
      check1($sformatf("vec%0d parity_error", i), parity_error, 1'b0);
      check1($sformatf("vec%0d busy", i), busy, 1'b0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r_en = 1'($urandom_range(0, 1));
      r_rw = 1'($urandom_range(0, 1));
      r_fe = 1'($urandom_range(0, 1));
      r_be = BW'($urandom_range(0, 15));
      r_d  = $urandom;
      r_a  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1020, 1030)) : AW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       r_fa = r_a;
        1:       r_fa = AW'($urandom_range(1020, 1030));
        default: r_fa = AW'($urandom_range(0, 15));
      endcase
      apply(r_en, r_rw, r_be, r_a, r_d, r_fe, r_fa);
      exp_q.push_back(m_dout);
      q_exp = exp_q.pop_front();
      check($sformatf("rand%0d data_out", n), data_out, q_exp);
      check1($sformatf("rand%0d data_valid", n), data_valid, m_dv);
      check($sformatf("rand%0d fetch_out", n), fetch_out, m_fout);
      check1($sformatf("rand%0d fetch_valid", n), fetch_valid, m_fv);
      check1($sformatf("rand%0d addr_error", n), addr_error, m_err);
      check1($sformatf("rand%0d parity_error", n), parity_error, 1'b0);
    end
    idle_inputs();

    // Reset in the middle of a clear restarts it from word 0
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check1("midclear busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset3");
    @(negedge clk);
    reset_n = 1'b1;
    wait_clear("clear2");

    apply(1'b1, 1'b1, 4'h0, 16'd0, '0, 1'b1, 16'd1023);
    check("clear2 word0", data_out, 32'h0);
    check1("clear2 word0 valid", data_valid, 1'b1);
    check("clear2 word1023", fetch_out, 32'h0);
    check1("clear2 word1023 valid", fetch_valid, 1'b1);

`ifdef RAM_PARITY_EN
    apply(1'b1, 1'b0, 4'hF, 16'd3, 32'h0000_00F0, 1'b0, 16'd0);
    dut.mem[3][0] = ~dut.mem[3][0];
    exp_mem[3][0] = ~exp_mem[3][0];
    apply(1'b0, 1'b0, 4'h0, 16'd0, '0, 1'b1, 16'd3);
    check("parity fetch_out", fetch_out, 32'h0000_00F1);
    check1("parity fetch_valid", fetch_valid, 1'b1);
    check1("parity parity_error", parity_error, 1'b1);
    apply(1'b0, 1'b0, 4'h0, 16'd0, '0, 1'b1, 16'd4);
    check1("parity clean word", parity_error, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
